tristate_bus_arbiter: RTL and testbench

//   Round-robin controller for a shared 4-source tristate data bus built from tristate drivers.

---
 rtl/tristate_bus_arbiter.sv | 116 +++++++++++
 tb/tb_tristate_bus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a 4-source shared tristate bus.
// One-hot drive enables, break-before-make idle gap, registered capture of the bus.
module tristate_bus_arbiter #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] bus_in,
  output logic [3:0]       en,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [1:0]       dout_src,
  output logic             busy
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned CW   = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t           state, state_n;
  logic [1:0]       last, last_n;
  logic [1:0]       sel_n, dout_src_n;
  logic [1:0]       winner, idx;
  logic             found;
  logic [NSRC-1:0]  en_n;
  logic [CW-1:0]    gap_cnt, gap_n;
  logic [WIDTH-1:0] dout_n;
  logic             dout_valid_n;

  // First requesting source after the last winner, wrapping around
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = last;
    for (int i = 1; i <= int'(NSRC); i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    last_n       = last;
    sel_n        = sel;
    en_n         = en;
    dout_n       = dout;
    dout_src_n   = dout_src;
    dout_valid_n = 1'b0;
    gap_n        = gap_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          en_n    = NSRC'(1) << winner;
          sel_n   = winner;
          last_n  = winner;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        dout_n       = bus_in;
        dout_src_n   = sel;
        dout_valid_n = 1'b1;
        en_n         = '0;
        gap_n        = CW'(GAP_CYCLES - 1);
        state_n      = GAP;
      end
      GAP: begin
        en_n = '0;
        if (gap_cnt == '0) begin
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt - CW'(1);
        end
      end
      default: begin
        en_n    = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 2'd3;
      sel        <= '0;
      en         <= '0;
      gnt        <= '0;
      dout       <= '0;
      dout_src   <= '0;
      dout_valid <= 1'b0;
      gap_cnt    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      last       <= last_n;
      sel        <= sel_n;
      en         <= en_n;
      gnt        <= en_n;
      dout       <= dout_n;
      dout_src   <= dout_src_n;
      dout_valid <= dout_valid_n;
      gap_cnt    <= gap_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: two instances (gap 1 and gap 3) on modelled tristate buses,
// checked every cycle against a transaction-level timeline model.
module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] pat [4];

  wire  [3:0] bus_a, bus_b;
  logic [3:0] en_a, en_b, gnt_a, gnt_b, dout_a, dout_b;
  logic [1:0] sel_a, sel_b, src_a, src_b;
  logic       dv_a, dv_b, busy_a, busy_b;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_drv
    assign bus_a = en_a[g] ? pat[g] : 4'bz;
    assign bus_b = en_b[g] ? pat[g] : 4'bz;
  end

  tristate_bus_arbiter #(.WIDTH(4), .GAP_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .req(req), .bus_in(bus_a), .en(en_a), .gnt(gnt_a), .sel(sel_a),
    .dout(dout_a), .dout_valid(dv_a), .dout_src(src_a), .busy(busy_a));

  tristate_bus_arbiter #(.WIDTH(4), .GAP_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .req(req), .bus_in(bus_b), .en(en_b), .gnt(gnt_b), .sel(sel_b),
    .dout(dout_b), .dout_valid(dv_b), .dout_src(src_b), .busy(busy_b));

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int gap_of [2] = '{1, 3};

  // Timeline model: edges to skip before next arbitration, pending capture, rotation pointer
  int         m_wait [2];
  int         m_pend [2];
  int         m_ptr  [2];
  logic [3:0] m_en   [2];
  logic [3:0] m_dout [2];
  logic [1:0] m_sel  [2];
  logic [1:0] m_src  [2];
  logic       m_dv   [2];

  logic [3:0] prev_en [2];
  int         zrun    [2];
  bit         had     [2];
  int         glog_src [2][16];
  int         glog_cyc [2][16];
  int         gn       [2];

  task automatic chk(input string tag, input int inst, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s inst=%0d cyc=%0d observed=%h expected=%h", tag, inst, cyc, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    bit found;
    int c;
    if (rst) begin
      m_wait[i] = 0; m_pend[i] = -1; m_ptr[i] = 3;
      m_en[i] = 0; m_dout[i] = 0; m_sel[i] = 0; m_src[i] = 0; m_dv[i] = 0;
      return;
    end
    m_dv[i] = 0;
    m_en[i] = 0;
    if (m_pend[i] >= 0) begin
      m_dout[i] = pat[m_pend[i]];
      m_src[i]  = 2'(m_pend[i]);
      m_dv[i]   = 1;
      m_pend[i] = -1;
    end
    if (m_wait[i] > 0) begin
      m_wait[i]--;
    end else if (req != 0) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr[i] + k) % 4;
        if (!found && req[c]) begin
          found     = 1;
          m_ptr[i]  = c;
          m_en[i]   = 4'(1 << c);
          m_sel[i]  = 2'(c);
          m_pend[i] = c;
          m_wait[i] = 1 + gap_of[i];
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [3:0] en, input logic [3:0] gnt,
                            input logic [1:0] sel, input logic [3:0] dout, input logic dv,
                            input logic [1:0] src, input logic busy, input logic [3:0] bus);
    chk("en", i, 8'(en), 8'(m_en[i]));
    chk("gnt", i, 8'(gnt), 8'(m_en[i]));
    chk("sel", i, 8'(sel), 8'(m_sel[i]));
    chk("dout", i, 8'(dout), 8'(m_dout[i]));
    chk("dout_valid", i, 8'(dv), 8'(m_dv[i]));
    chk("dout_src", i, 8'(src), 8'(m_src[i]));
    chk("busy", i, 8'(busy), 8'(m_wait[i] > 0));
    chk("onehot0", i, 8'($onehot0(en)), 8'd1);
    if (prev_en[i] != 0) chk("no_make_before_break", i, 8'(en), 8'd0);
    if (en != 0) begin
      chk("bus_known", i, 8'($isunknown(bus)), 8'd0);
      if (prev_en[i] == 0) begin
        if (had[i]) chk("gap_len", i, 8'(zrun[i] >= gap_of[i]), 8'd1);
        had[i] = 1;
        zrun[i] = 0;
        if (gn[i] < 16) begin
          glog_src[i][gn[i]] = $clog2(int'(en));
          glog_cyc[i][gn[i]] = cyc;
          gn[i]++;
        end
      end
    end else begin
      zrun[i]++;
    end
    if (rst) had[i] = 0;
    prev_en[i] = en;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    #1;
    check_inst(0, en_a, gnt_a, sel_a, dout_a, dv_a, src_a, busy_a, bus_a);
    check_inst(1, en_b, gnt_b, sel_b, dout_b, dv_b, src_b, busy_b, bus_b);
  endtask

  task automatic do_reset();
    rst = 1; req = 0;
    tick();
    rst = 0;
    gn[0] = 0; gn[1] = 0;
  endtask

  initial begin
    rst = 1; req = 0;
    pat[0] = 4'h3; pat[1] = 4'h5; pat[2] = 4'hA; pat[3] = 4'hC;
    for (int i = 0; i < 2; i++) begin
      prev_en[i] = 0; zrun[i] = 0; had[i] = 0; gn[i] = 0;
      m_wait[i] = 0; m_pend[i] = -1; m_ptr[i] = 3;
      m_en[i] = 0; m_dout[i] = 0; m_sel[i] = 0; m_src[i] = 0; m_dv[i] = 0;
    end

    // Single request from source 2
    do_reset();
    chk("reset_en", 0, 8'(en_a), 8'd0);
    chk("reset_busy", 0, 8'(busy_a), 8'd0);
    req = 4'b0100;
    tick();
    chk("t1_en", 0, 8'(en_a), 8'h04);
    req = 0;
    tick();
    chk("t1_en_off", 0, 8'(en_a), 8'd0);
    chk("t1_dv", 0, 8'(dv_a), 8'd1);
    chk("t1_dout", 0, 8'(dout_a), 8'h0A);
    chk("t1_src", 0, 8'(src_a), 8'd2);
    tick();
    chk("t1_dv_pulse", 0, 8'(dv_a), 8'd0);
    chk("t1_sel_hold", 0, 8'(sel_a), 8'd2);
    repeat (4) tick();

    // All sources requesting: 0,1,2,3,0 every 3 cycles at gap 1
    do_reset();
    req = 4'b1111;
    repeat (16) tick();
    chk("t2_ngrants", 0, 8'(gn[0] >= 5), 8'd1);
    for (int k = 0; k < 5; k++) begin
      chk("t2_order", 0, 8'(glog_src[0][k]), 8'(k % 4));
      if (k > 0) chk("t2_spacing", 0, 8'(glog_cyc[0][k] - glog_cyc[0][k-1]), 8'd3);
    end

    // Two sources at gap 3: 0,1,0 every 5 cycles
    do_reset();
    req = 4'b0011;
    repeat (12) tick();
    chk("t4_ngrants", 1, 8'(gn[1] >= 3), 8'd1);
    for (int k = 0; k < 3; k++) begin
      chk("t4_order", 1, 8'(glog_src[1][k]), 8'(k % 2));
      if (k > 0) chk("t4_spacing", 1, 8'(glog_cyc[1][k] - glog_cyc[1][k-1]), 8'd5);
    end
    req = 0;
    repeat (6) tick();

    // Reset lands on the DRIVE cycle
    do_reset();
    req = 4'b0100;
    tick();
    chk("t5_drive", 0, 8'(en_a), 8'h04);
    rst = 1; req = 4'b1001;
    tick();
    rst = 0;
    chk("t5_en", 0, 8'(en_a), 8'd0);
    chk("t5_dv", 0, 8'(dv_a), 8'd0);
    chk("t5_dout", 0, 8'(dout_a), 8'd0);
    tick();
    chk("t5_winner0", 0, 8'(en_a), 8'h01);
    chk("t5_winner0_b", 1, 8'(en_b), 8'h01);
    req = 0;
    repeat (6) tick();

    // Request dropped during DRIVE still completes
    do_reset();
    req = 4'b0100;
    tick();
    req = 0;
    tick();
    chk("t6_dv", 0, 8'(dv_a), 8'd1);
    chk("t6_src", 0, 8'(src_a), 8'd2);
    tick();
    chk("t6_idle", 0, 8'(busy_a), 8'd0);
    repeat (4) tick();

    // Random requests, data and occasional resets
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      req = 4'($urandom_range(0, 15));
      for (int s = 0; s < 4; s++) pat[s] = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; req = 0;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
